// File: rtl/neuron_ctrl_pkg.sv
// Shared types and constants for the neuron update controller.
// Holds the state encoding, the default accumulator width and the 8-bit signed limits.
package neuron_ctrl_pkg;

    localparam int unsigned ACC_W_DEF = 10;

    localparam logic signed [7:0] S8_MAX = 8'sh7f;
    localparam logic signed [7:0] S8_MIN = 8'sh80;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ACCUM = 3'd1;
    localparam logic [2:0] ST_LEAK  = 3'd2;
    localparam logic [2:0] ST_FIRE  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;

    typedef enum logic [2:0] {
        StIdle  = ST_IDLE,
        StAccum = ST_ACCUM,
        StLeak  = ST_LEAK,
        StFire  = ST_FIRE,
        StWrite = ST_WRITE
    } state_e;

endpackage

// File: rtl/neuron_update_controller_sat_add.sv
// Combinational signed add in ACC_W bits, clamped back to the signed 8-bit range.
module neuron_sat_add
    import neuron_ctrl_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic signed [7:0] a,
    input  logic signed [7:0] b,
    output logic signed [7:0] sum
);

    localparam logic signed [ACC_W-1:0] MAX_EXT = {{(ACC_W-8){S8_MAX[7]}}, S8_MAX};
    localparam logic signed [ACC_W-1:0] MIN_EXT = {{(ACC_W-8){S8_MIN[7]}}, S8_MIN};

    logic signed [ACC_W-1:0] a_ext;
    logic signed [ACC_W-1:0] b_ext;
    logic signed [ACC_W-1:0] sum_ext;

    always_comb begin
        a_ext   = {{(ACC_W-8){a[7]}}, a};
        b_ext   = {{(ACC_W-8){b[7]}}, b};
        sum_ext = a_ext + b_ext;
        if (sum_ext > MAX_EXT) begin
            sum = S8_MAX;
        end else if (sum_ext < MIN_EXT) begin
            sum = S8_MIN;
        end else begin
            sum = sum_ext[7:0];
        end
    end

endmodule

// File: rtl/neuron_update_controller.sv
// Per-tick neuron update sequencer: load potential, integrate events, leak, fire/reset,
// then write the new potential back once the Wishbone side of the parameter block is idle.
module neuron_update_controller
    import neuron_ctrl_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              tick_i,
    input  logic              evt_valid_i,
    output logic              evt_ready_o,
    input  logic [1:0]        evt_type_i,
    input  logic              evt_conn_i,
    input  logic              evt_last_i,
    input  logic signed [7:0] voltage_potential_i,
    input  logic signed [7:0] pos_threshold_i,
    input  logic signed [7:0] neg_threshold_i,
    input  logic signed [7:0] leak_value_i,
    input  logic signed [7:0] pos_reset_i,
    input  logic signed [7:0] neg_reset_i,
    input  logic signed [7:0] weight_type1_i,
    input  logic signed [7:0] weight_type2_i,
    input  logic signed [7:0] weight_type3_i,
    input  logic signed [7:0] weight_type4_i,
    input  logic [7:0]        weight_select_i,
    input  logic              bus_busy_i,
    output logic signed [7:0] ext_voltage_potential_o,
    output logic              ext_write_enable_o,
    output logic              spike_o,
    output logic              done_o,
    output logic              busy_o,
    output logic              tick_overrun_o
);

    state_e            state_q;
    logic signed [7:0] v_q;
    logic signed [7:0] weight;
    logic signed [7:0] operand;
    logic signed [7:0] sum;
    logic signed [7:0] fire_v;
    logic              fire_pos;
    logic              evt_hit;

    always_comb begin
        unique case (evt_type_i)
            2'd0:    weight = weight_type1_i;
            2'd1:    weight = weight_type2_i;
            2'd2:    weight = weight_type3_i;
            default: weight = weight_type4_i;
        endcase
        // One adder serves both ACCUM (weight) and LEAK (leak value).
        operand  = (state_q == StLeak) ? leak_value_i : weight;
        evt_hit  = evt_valid_i & evt_conn_i & weight_select_i[{1'b0, evt_type_i}];
        fire_pos = (v_q >= pos_threshold_i);
        if (fire_pos) begin
            fire_v = pos_reset_i;
        end else if (v_q <= neg_threshold_i) begin
            fire_v = neg_reset_i;
        end else begin
            fire_v = v_q;
        end
    end

    neuron_sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .a   (v_q),
        .b   (operand),
        .sum (sum)
    );

    assign evt_ready_o = (state_q == StAccum);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q                 <= StIdle;
            v_q                     <= '0;
            ext_voltage_potential_o <= '0;
            ext_write_enable_o      <= 1'b0;
            spike_o                 <= 1'b0;
            done_o                  <= 1'b0;
            busy_o                  <= 1'b0;
            tick_overrun_o          <= 1'b0;
        end else begin
            spike_o <= 1'b0;
            done_o  <= 1'b0;
            if (tick_i && (state_q != StIdle)) begin
                tick_overrun_o <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (tick_i) begin
                        v_q     <= voltage_potential_i;
                        busy_o  <= 1'b1;
                        state_q <= StAccum;
                    end
                end
                StAccum: begin
                    if (evt_valid_i) begin
                        if (evt_hit) begin
                            v_q <= sum;
                        end
                        if (evt_last_i) begin
                            state_q <= StLeak;
                        end
                    end
                end
                StLeak: begin
                    v_q     <= sum;
                    state_q <= StFire;
                end
                StFire: begin
                    v_q                     <= fire_v;
                    ext_voltage_potential_o <= fire_v;
                    ext_write_enable_o      <= 1'b1;
                    spike_o                 <= fire_pos;
                    state_q                 <= StWrite;
                end
                StWrite: begin
                    if (!bus_busy_i) begin
                        ext_write_enable_o <= 1'b0;
                        done_o             <= 1'b1;
                        busy_o             <= 1'b0;
                        state_q            <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
